// File: rtl/latch.sv
// Level-sensitive D latch with async clear (dominant) and async preset.
// Transparent while gate is high, holds the last passed value while low.
module latch #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             aset,
  input  logic             aclr,
  input  logic             gate,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // No final else: the missing branch is the hold state of the latch.
  always_latch begin
    if (!aclr)
      q <= CLR_VALUE;
    else if (aset)
      q <= SET_VALUE;
    else if (gate)
      q <= d;
  end

endmodule

// File: tb/tb_latch.sv
// Self-checking bench for latch: three widths/parameter sets
// driven in lockstep against a priority-rule reference model.
module tb_latch;

  logic       aclr;
  logic       aset;
  logic       gate;
  logic [7:0] d;
  logic [3:0] d4;
  logic [0:0] d1;
  logic [7:0] q8;
  logic [3:0] q4;
  logic [0:0] q1;

  int errors;
  int checks;

  logic [7:0] m8;
  logic [3:0] m4;
  logic [0:0] m1;

  assign d4 = d[7:4];
  assign d1 = d[0:0];

  latch #(.WIDTH(8)) u8 (
    .aset(aset), .aclr(aclr), .gate(gate),
    .d(d), .q(q8)
  );

  latch #(
    .WIDTH(4), .CLR_VALUE(4'h5), .SET_VALUE(4'hA)
  ) u4 (
    .aset(aset), .aclr(aclr), .gate(gate),
    .d(d4), .q(q4)
  );

  latch #(.WIDTH(1)) u1 (
    .aset(aset), .aclr(aclr), .gate(gate),
    .d(d1), .q(q1)
  );

  // Drive inputs and record what each latch should now be showing.
  task automatic apply(input logic c, input logic s,
                       input logic g, input logic [7:0] v);
    aclr = c;
    aset = s;
    gate = g;
    d    = v;
    if (!c) begin
      m8 = 8'h00; m4 = 4'h5; m1 = 1'b0;
    end else if (s) begin
      m8 = 8'hFF; m4 = 4'hA; m1 = 1'b1;
    end else if (g) begin
      m8 = v; m4 = v[7:4]; m1 = v[0:0];
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 50; i++) begin
      apply(1'b0, 1'b0, i[0], 8'h00);
      checks++;
      if ({q8, q4, q1} !== {8'h00, 4'h5, 1'b0}) begin
        errors++;
        $display("FAIL reset t=%0t got q8=%h q4=%h q1=%b want 00 5 0",
                 $time, q8, q4, q1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, i[0], 8'h3C);
      checks++;
      if ({q8, q4, q1} !== {8'h00, 4'h5, 1'b0}) begin
        errors++;
        $display("FAIL clr_dominates got q8=%h q4=%h q1=%b want 00 5 0",
                 q8, q4, q1);
      end
    end
  endtask

  task automatic test_preset();
    for (int i = 0; i < 50; i++) begin
      apply(1'b1, 1'b1, i[0], 8'h00);
      checks++;
      if ({q8, q4, q1} !== {8'hFF, 4'hA, 1'b1}) begin
        errors++;
        $display("FAIL preset t=%0t got q8=%h q4=%h q1=%b want ff a 1",
                 $time, q8, q4, q1);
      end
    end
    // Release preset while gate low: preset value must stick.
    apply(1'b1, 1'b1, 1'b0, 8'h12);
    apply(1'b1, 1'b0, 1'b0, 8'h12);
    checks++;
    if ({q8, q4, q1} !== {8'hFF, 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL preset_rel_lo got q8=%h q4=%h q1=%b want ff a 1",
               q8, q4, q1);
    end
    apply(1'b1, 1'b0, 1'b1, 8'h12);
    checks++;
    if ({q8, q4, q1} !== {8'h12, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL preset_rel_rise got q8=%h q4=%h q1=%b want 12 1 0",
               q8, q4, q1);
    end
    // Release preset while gate high: q takes d at once.
    apply(1'b1, 1'b1, 1'b1, 8'h66);
    apply(1'b1, 1'b0, 1'b1, 8'h66);
    checks++;
    if ({q8, q4, q1} !== {8'h66, 4'h6, 1'b0}) begin
      errors++;
      $display("FAIL preset_rel_hi got q8=%h q4=%h q1=%b want 66 6 0",
               q8, q4, q1);
    end
  endtask

  task automatic test_transparency();
    logic [7:0] seq [4];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1, seq[i]);
      checks++;
      if ({q8, q4, q1} !== {seq[i], seq[i][7:4], seq[i][0]}) begin
        errors++;
        $display("FAIL transparent got q8=%h q4=%h q1=%b want d=%h",
                 q8, q4, q1, seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    apply(1'b1, 1'b0, 1'b1, 8'hFF);
    apply(1'b1, 1'b0, 1'b0, 8'hFF);
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({q8, q4, q1} !== {8'hFF, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL hold got q8=%h q4=%h q1=%b want ff f 1",
               q8, q4, q1);
    end
    apply(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if ({q8, q4, q1} !== {8'h00, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL hold_reopen got q8=%h q4=%h q1=%b want 00 0 0",
               q8, q4, q1);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       g;
    g = 1'b0;
    for (int i = 0; i < 50; i++) begin
      v = 8'($urandom);
      apply(1'b1, 1'b0, g, v);
      for (int k = 0; k < 10; k++) begin
        g = ~g;
        apply(1'b1, 1'b0, g, v);
        checks++;
        if ({q8, q4, q1} !== {m8, m4, m1}) begin
          errors++;
          $display("FAIL random it=%0d g=%b got q8=%h q4=%h q1=%b want %h %h %b",
                   i, g, q8, q4, q1, m8, m4, m1);
        end
      end
    end
  endtask

  task automatic test_mid_clear();
    apply(1'b1, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, i[0], 8'hA5);
      checks++;
      if ({q8, q4, q1} !== {8'h00, 4'h5, 1'b0}) begin
        errors++;
        $display("FAIL mid_clear got q8=%h q4=%h q1=%b want 00 5 0",
                 q8, q4, q1);
      end
    end
    apply(1'b1, 1'b0, 1'b0, 8'hA5);
    checks++;
    if ({q8, q4, q1} !== {8'h00, 4'h5, 1'b0}) begin
      errors++;
      $display("FAIL clear_rel_lo got q8=%h q4=%h q1=%b want 00 5 0",
               q8, q4, q1);
    end
    apply(1'b1, 1'b0, 1'b1, 8'hA5);
    checks++;
    if ({q8, q4, q1} !== {8'hA5, 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL clear_reload got q8=%h q4=%h q1=%b want a5 a 1",
               q8, q4, q1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m8 = 8'h00; m4 = 4'h5; m1 = 1'b0;
    aclr = 1'b0; aset = 1'b0; gate = 1'b0; d = 8'h00;
    #1;
    test_reset();
    test_preset();
    test_transparency();
    test_hold();
    test_random();
    test_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch.md
Name: latch

Overview:
- Parameterised level-sensitive D latch, width WIDTH.
- Asynchronous active-low clear and asynchronous active-high preset.
- Used as a storage/hold element in gate-enabled datapaths.
- Transparent while gate is high; holds its last value while gate is low.

Parameters:
- WIDTH, 1: data width of d and q; legal range is 1 or more.
- CLR_VALUE, {WIDTH{1'b0}}: value forced onto q while clear is active.
- SET_VALUE, {WIDTH{1'b1}}: value forced onto q while preset is active and clear is inactive.

Ports:
- gate, input, 1: latch enable, the block's single clock. High = transparent, low = hold.
- aclr, input, 1: reset. Asynchronous, active-low clear. 0 forces q to CLR_VALUE.
- aset, input, 1: asynchronous, active-high preset. 1 forces q to SET_VALUE when aclr=1.
- d, input, WIDTH: data input.
- q, output, WIDTH: latched data output.
- Positional instantiation order is fixed: (aset, aclr, gate, d, q). The port declaration must follow this order.

Behaviour:
- Priority, highest first:
  - aclr=0: q=CLR_VALUE.
  - else aset=1: q=SET_VALUE.
  - else gate=1: q follows d.
  - else: q holds.
- Clear dominates preset. aclr=0 with aset=1 gives q=CLR_VALUE.
- Clear and preset are asynchronous. They take effect immediately, independent of gate level and edges, and persist for as long as they are asserted.
- Transparent mode (aclr=1, aset=0, gate=1):
  - Every change on d propagates to q combinationally, with zero cycles of latency.
  - There is no edge sampling.
- Hold mode (aclr=1, aset=0, gate=0):
  - q retains the value d had at the moment gate fell.
  - d changes are ignored.
- Release of clear or preset:
  - If gate=1 at release, q immediately takes d.
  - If gate=0 at release, q keeps CLR_VALUE or SET_VALUE until gate next goes high.
- Simultaneous gate fall and d change: the implementation must not depend on this ordering. The verification bench changes d only away from gate transitions.
- Power-up (before any clear): q is X until the first clear, preset, or transparent phase. A clear must be applied at start-up.
- Width rules:
  - All bits are independent and bit-parallel.
  - d and q are exactly WIDTH bits.
  - CLR_VALUE and SET_VALUE are truncated or zero-extended to WIDTH.
- Implementation:
  - A single always block, sensitive to aclr, aset, gate and d.
  - Use if/else priority and non-blocking assignment.
  - Lint latch inference is intentional and waived.
  - No internal flops and no other clocks.

Test Plan:
1. Clear dominance at reset: aclr=0, aset=0, gate toggling period 2, d=0 for 50 time units -> q=0 throughout. Then drive aset=1 while aclr=0 -> q stays 0.
2. Async preset: aclr=1, aset=1 for 50 units with gate toggling and d=0 -> q=1 (SET_VALUE) throughout, including during gate-high phases.
3. Transparency: aclr=1, aset=0, gate=1, d stepped 0->1->0 -> q tracks d with no delay.
4. Hold: gate high with d=1, gate falls, then d=0 with gate low -> q stays 1. On the next gate rise, q becomes 0.
5. Random data: 50 iterations, d=$random every 10 units, gate toggling every 1 unit -> at each gate-high instant q==d. During gate-low, q equals d as sampled at the last gate fall.
6. Mid-operation clear: during random data with q=1, pulse aclr=0 for 3 units -> q=0 immediately. After aclr returns to 1, q reloads d on the next gate-high. Repeat at WIDTH=8 with d=8'hA5 -> q=8'hA5 when transparent and 8'h00 on clear.
